// File: rtl/adder_sched_pkg.sv
// Shared types and sizing for the nibble-serial adder scheduler.
// Holds the FSM state enum, the slice width and the beat-count helper.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE = 4;

  // One beat per nibble of the operand width.
  function automatic int beats(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/adder_scheduler_nibble.sv
// 4-bit adder slice built from generate/propagate prefix carries.
// Ports: a[3:0], b[3:0], cin -> sum[3:0], cout.
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is formed directly from g/p and cin, so no
  // carry ripples through the slice.
  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/adder_scheduler.sv
// Two requesters share one 4-bit adder slice, one nibble per cycle.
// Ports: clk, rst (async high), reqN_valid/ready/a/b, rsp_valid/ready/id/sum, busy.
// Macro ROUND_ROBIN_EN: round-robin ties; undefined gives req0 fixed priority.
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_sum,
  output logic             busy
);

  localparam int BEATS = beats(WIDTH);
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             id_q, id_d;

  logic             win1;
  logic             idle_ok;
  logic             accept;
  logic             last_beat;
  logic [3:0]       na, nb, ns;
  logic             nco;
  int               idx;

  // Readies are also held low while rst is high.
  assign idle_ok   = (state_q == IDLE) && !rst;
  assign accept    = idle_ok && (req0_valid || req1_valid);
  assign last_beat = (cnt_q == LAST);

  // ---------------- arbitration ----------------
`ifdef ROUND_ROBIN_EN
  // ptr_q high means req1 wins the next tie.
  logic ptr_q, ptr_d;

  always_comb begin
    win1 = 1'b0;
    if (req0_valid && req1_valid) begin
      win1 = ptr_q;
    end else begin
      win1 = req1_valid;
    end
  end

  // Favour whoever was not granted on this acceptance.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = !win1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win1 = !req0_valid && req1_valid;
  end
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req0_ready = idle_ok && req0_valid && !win1;
    req1_ready = idle_ok && req1_valid && win1;
    busy       = (state_q == RUN) || (state_q == DONE);
    rsp_valid  = (state_q == DONE);
  end

  // ---------------- datapath ----------------
  assign idx = NIBBLE * int'(cnt_q);
  assign na  = a_q[idx +: NIBBLE];
  assign nb  = b_q[idx +: NIBBLE];

  nibble_adder u_slice (
    .a    (na),
    .b    (nb),
    .cin  (cy_q),
    .sum  (ns),
    .cout (nco)
  );

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    cnt_d = cnt_q;
    cy_d  = cy_q;
    id_d  = id_q;
    if (accept) begin
      a_d   = win1 ? req1_a : req0_a;
      b_d   = win1 ? req1_b : req0_b;
      id_d  = win1;
      cnt_d = '0;
      cy_d  = 1'b0;
    end else if (state_q == RUN) begin
      res_d[idx +: NIBBLE] = ns;
      cy_d = nco;
      // Counter parks on the last beat; it never wraps.
      if (!last_beat) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      cy_q  <= 1'b0;
      id_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      cy_q  <= cy_d;
      id_q  <= id_d;
    end
  end

  // Final carry-out sits above the result nibbles.
  assign rsp_sum = {cy_q, res_q};
  assign rsp_id  = id_q;

endmodule
